// File: rtl/riscv_i32_trap_handler.sv
// riscv_i32_trap_handler
// Machine-mode trap sequencer for the RV32I core. Consumes the per-cycle
// trap / mret / interrupt indication and maintains mstatus (MIE, MPIE, MPP),
// mepc, mcause, mtval, mtvec and the debug PC. It issues a registered fetch
// redirect and parks the core in a debug-halted state on ebreak-to-debug.
//
// Handshake: trap_redirect__valid is a single-cycle pulse with no ready.
// Fetch must take trap_redirect__pc in the cycle the pulse is high. The trap
// inputs have no ready either. They are only acted on in IDLE. In REDIRECT
// (pipeline flushing) and HALTED they are dropped.
module riscv_i32_trap_handler #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        control_flow__trap__valid,
   input  logic [2:0]  control_flow__trap__to_mode,
   input  logic [3:0]  control_flow__trap__cause,
   input  logic [31:0] control_flow__trap__pc,
   input  logic [31:0] control_flow__trap__value,
   input  logic        control_flow__trap__ret,
   input  logic        control_flow__trap__vector,
   input  logic        control_flow__trap__ebreak_to_dbg,
   input  logic        control_flow__async_cancel,
   input  logic        csr_write__valid,
   input  logic [11:0] csr_write__address,
   input  logic [31:0] csr_write__data,
   input  logic        dbg_resume,
   output logic        trap_redirect__valid,
   output logic [31:0] trap_redirect__pc,
   output logic [31:0] csrs__mepc,
   output logic [31:0] csrs__mcause,
   output logic [31:0] csrs__mtval,
   output logic [31:0] csrs__mtvec,
   output logic        csrs__mstatus_mie,
   output logic [2:0]  csrs__mode,
   output logic        dbg_halted,
   output logic [1:0]  o_fsm_state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_DPC     = 12'h7b1;
   localparam logic [2:0]  MODE_M      = 3'b011;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;
   logic        r_halted;

   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [31:0] r_mtvec;
   logic [31:0] r_dpc;
   logic        r_mie;
   logic        r_mpie;
   logic [2:0]  r_mpp;
   logic [2:0]  r_mode;

   logic        w_take_trap;
   logic        w_take_dbg;
   logic        w_take_ret;
   logic [31:0] w_target;
   logic [31:0] w_mtvec_base;
   logic [31:0] w_trap_target;

   logic        w_wr_mstatus;
   logic        w_wr_mtvec;
   logic        w_wr_mepc;
   logic        w_wr_mcause;
   logic        w_wr_mtval;
   logic        w_wr_dpc;

   // Target mode and vector hint carry no information for an M-only core.
   logic        w_unused;
   assign w_unused = ^{control_flow__trap__to_mode, control_flow__trap__vector};

   // Vectored mode applies only to interrupts: base + 4 * cause.
   assign w_mtvec_base  = {r_mtvec[31:2], 2'b00};
   assign w_trap_target = (control_flow__async_cancel && r_mtvec[0])
                          ? (w_mtvec_base + {26'd0, control_flow__trap__cause, 2'b00})
                          : w_mtvec_base;

   // CSR write address decode.
   always_comb begin
      w_wr_mstatus = csr_write__valid && (csr_write__address == CSR_MSTATUS);
      w_wr_mtvec   = csr_write__valid && (csr_write__address == CSR_MTVEC);
      w_wr_mepc    = csr_write__valid && (csr_write__address == CSR_MEPC);
      w_wr_mcause  = csr_write__valid && (csr_write__address == CSR_MCAUSE);
      w_wr_mtval   = csr_write__valid && (csr_write__address == CSR_MTVAL);
      w_wr_dpc     = csr_write__valid && (csr_write__address == CSR_DPC);
   end

   // Next-state logic, trap/ret/debug event decode and redirect target select.
   always_comb begin
      w_next_state = r_state;
      w_take_trap  = 1'b0;
      w_take_dbg   = 1'b0;
      w_take_ret   = 1'b0;
      w_target     = r_redirect_pc;
      case (r_state)
         ST_IDLE: begin
            if (control_flow__trap__valid) begin
               if (control_flow__trap__ebreak_to_dbg) begin
                  w_take_dbg   = 1'b1;
                  w_next_state = ST_HALTED;
               end else begin
                  w_take_trap  = 1'b1;
                  w_target     = w_trap_target;
                  w_next_state = ST_REDIRECT;
               end
            end else if (control_flow__trap__ret) begin
               w_take_ret   = 1'b1;
               w_target     = r_mepc;
               w_next_state = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            w_next_state = ST_IDLE;
         end
         ST_HALTED: begin
            if (dbg_resume) begin
               w_target     = r_dpc;
               w_next_state = ST_REDIRECT;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register plus registered redirect pulse and halted flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_halted         <= 1'b0;
      end else begin
         r_state          <= w_next_state;
         r_redirect_valid <= (w_next_state == ST_REDIRECT);
         r_halted         <= (w_next_state == ST_HALTED);
         if (w_next_state == ST_REDIRECT) begin
            r_redirect_pc <= w_target;
         end
      end
   end

   // CSR update: trap/ret/debug-entry updates win over a same-cycle write
   // to the same register; writes to untouched registers still land.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mepc   <= 32'd0;
         r_mcause <= 32'd0;
         r_mtval  <= 32'd0;
         r_mtvec  <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
         r_dpc    <= 32'd0;
         r_mie    <= 1'b0;
         r_mpie   <= 1'b0;
         r_mpp    <= 3'b000;
         r_mode   <= MODE_M;
      end else begin
         if (w_take_trap) begin
            r_mepc   <= {control_flow__trap__pc[31:1], 1'b0};
            r_mcause <= {control_flow__async_cancel, 27'd0, control_flow__trap__cause};
            r_mtval  <= control_flow__trap__value;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mpp    <= r_mode;
            r_mode   <= MODE_M;
         end else if (w_take_ret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_mode   <= r_mpp;
            r_mpp    <= 3'b000;
         end
         if (w_take_dbg) begin
            r_dpc <= control_flow__trap__pc;
         end

         if (w_wr_mstatus && !w_take_trap && !w_take_ret) begin
            r_mie  <= csr_write__data[3];
            r_mpie <= csr_write__data[7];
            r_mpp  <= {1'b0, csr_write__data[12:11]};
         end
         if (w_wr_mtvec) begin
            r_mtvec <= {csr_write__data[31:2], 1'b0, csr_write__data[0]};
         end
         if (w_wr_mepc && !w_take_trap) begin
            r_mepc <= {csr_write__data[31:1], 1'b0};
         end
         if (w_wr_mcause && !w_take_trap) begin
            r_mcause <= csr_write__data;
         end
         if (w_wr_mtval && !w_take_trap) begin
            r_mtval <= csr_write__data;
         end
         if (w_wr_dpc && !w_take_dbg) begin
            r_dpc <= csr_write__data;
         end
      end
   end

   assign trap_redirect__valid = r_redirect_valid;
   assign trap_redirect__pc    = r_redirect_pc;
   assign csrs__mepc           = r_mepc;
   assign csrs__mcause         = r_mcause;
   assign csrs__mtval          = r_mtval;
   assign csrs__mtvec          = r_mtvec;
   assign csrs__mstatus_mie    = r_mie;
   assign csrs__mode           = r_mode;
   assign dbg_halted           = r_halted;
   assign o_fsm_state          = r_state;

endmodule

// File: tb/tb_riscv_i32_trap_handler.sv
// Bench for riscv_i32_trap_handler: directed scenarios followed by random
// traffic, checked against an architectural model of the trap CSRs.
module tb_riscv_i32_trap_handler;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic        control_flow__trap__valid;
   logic [2:0]  control_flow__trap__to_mode;
   logic [3:0]  control_flow__trap__cause;
   logic [31:0] control_flow__trap__pc;
   logic [31:0] control_flow__trap__value;
   logic        control_flow__trap__ret;
   logic        control_flow__trap__vector;
   logic        control_flow__trap__ebreak_to_dbg;
   logic        control_flow__async_cancel;
   logic        csr_write__valid;
   logic [11:0] csr_write__address;
   logic [31:0] csr_write__data;
   logic        dbg_resume;
   logic        trap_redirect__valid;
   logic [31:0] trap_redirect__pc;
   logic [31:0] csrs__mepc;
   logic [31:0] csrs__mcause;
   logic [31:0] csrs__mtval;
   logic [31:0] csrs__mtvec;
   logic        csrs__mstatus_mie;
   logic [2:0]  csrs__mode;
   logic        dbg_halted;
   logic [1:0]  o_fsm_state;

   riscv_i32_trap_handler #(.MTVEC_RESET(32'h0000_0100)) dut (
      .clk                               (clk),
      .reset                             (reset),
      .control_flow__trap__valid         (control_flow__trap__valid),
      .control_flow__trap__to_mode       (control_flow__trap__to_mode),
      .control_flow__trap__cause         (control_flow__trap__cause),
      .control_flow__trap__pc            (control_flow__trap__pc),
      .control_flow__trap__value         (control_flow__trap__value),
      .control_flow__trap__ret           (control_flow__trap__ret),
      .control_flow__trap__vector        (control_flow__trap__vector),
      .control_flow__trap__ebreak_to_dbg (control_flow__trap__ebreak_to_dbg),
      .control_flow__async_cancel        (control_flow__async_cancel),
      .csr_write__valid                  (csr_write__valid),
      .csr_write__address                (csr_write__address),
      .csr_write__data                   (csr_write__data),
      .dbg_resume                        (dbg_resume),
      .trap_redirect__valid              (trap_redirect__valid),
      .trap_redirect__pc                 (trap_redirect__pc),
      .csrs__mepc                        (csrs__mepc),
      .csrs__mcause                      (csrs__mcause),
      .csrs__mtval                       (csrs__mtval),
      .csrs__mtvec                       (csrs__mtvec),
      .csrs__mstatus_mie                 (csrs__mstatus_mie),
      .csrs__mode                        (csrs__mode),
      .dbg_halted                        (dbg_halted),
      .o_fsm_state                       (o_fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   // Architectural model of the handler.
   logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_dpc;
   logic        m_mie, m_mpie;
   logic [2:0]  m_mpp, m_mode;
   logic        m_halted;
   logic        m_flush;   // a redirect is being presented this cycle

   typedef struct {
      logic        valid;
      logic        dbg;
      logic        ret;
      logic        irq;
      logic [3:0]  cause;
      logic [31:0] pc;
      logic [31:0] value;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic        resume;
   } op_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = 32'h100; m_dpc = 0;
      m_mie = 0; m_mpie = 0; m_mpp = 3'b000; m_mode = 3'b011;
      m_halted = 0; m_flush = 0;
   endtask

   task automatic idle_inputs();
      control_flow__trap__valid         = 0;
      control_flow__trap__to_mode       = 3'b011;
      control_flow__trap__cause         = 0;
      control_flow__trap__pc            = 0;
      control_flow__trap__value         = 0;
      control_flow__trap__ret           = 0;
      control_flow__trap__vector        = 0;
      control_flow__trap__ebreak_to_dbg = 0;
      control_flow__async_cancel        = 0;
      csr_write__valid                  = 0;
      csr_write__address                = 0;
      csr_write__data                   = 0;
      dbg_resume                        = 0;
   endtask

   function automatic op_t nop();
      op_t o;
      o.valid = 0; o.dbg = 0; o.ret = 0; o.irq = 0; o.cause = 0;
      o.pc = 0; o.value = 0; o.wr = 0; o.addr = 0; o.data = 0; o.resume = 0;
      return o;
   endfunction

   task automatic check_outputs();
      chk("mepc",        csrs__mepc,   m_mepc);
      chk("mcause",      csrs__mcause, m_mcause);
      chk("mtval",       csrs__mtval,  m_mtval);
      chk("mtvec",       csrs__mtvec,  m_mtvec);
      chk("mie",         32'(csrs__mstatus_mie), 32'(m_mie));
      chk("mode",        32'(csrs__mode),        32'(m_mode));
      chk("dbg_halted",  32'(dbg_halted),        32'(m_halted));
      chk("redir_valid", 32'(trap_redirect__valid), 32'(m_flush));
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs, advances the model by the same cycle,
   // then checks the registered outputs just after the edge.
   task automatic apply(input op_t o);
      logic        t_trap, t_ret, t_dbg, n_flush;
      logic [31:0] tgt;
      control_flow__trap__valid         = o.valid;
      control_flow__trap__ebreak_to_dbg = o.dbg;
      control_flow__trap__ret           = o.ret;
      control_flow__async_cancel        = o.irq;
      control_flow__trap__cause         = o.cause;
      control_flow__trap__pc            = o.pc;
      control_flow__trap__value         = o.value;
      control_flow__trap__vector        = 1'($urandom_range(0, 1));
      csr_write__valid                  = o.wr;
      csr_write__address                = o.addr;
      csr_write__data                   = o.data;
      dbg_resume                        = o.resume;

      t_trap = 0; t_ret = 0; t_dbg = 0; n_flush = 0;
      if (m_flush) begin
         // flushing: trap inputs dropped
      end else if (m_halted) begin
         if (o.resume) begin
            exp_q.push_back(m_dpc);
            m_halted = 0;
            n_flush  = 1;
         end
      end else if (o.valid && o.dbg) begin
         m_dpc    = o.pc;
         m_halted = 1;
         t_dbg    = 1;
      end else if (o.valid) begin
         tgt = m_mtvec - (m_mtvec % 4);
         if (o.irq && (m_mtvec % 2 == 1)) tgt = tgt + 4 * 32'(o.cause);
         exp_q.push_back(tgt);
         m_mepc   = o.pc - (o.pc % 2);
         m_mcause = (o.irq ? 32'h8000_0000 : 32'h0) + 32'(o.cause);
         m_mtval  = o.value;
         m_mpie   = m_mie;
         m_mie    = 0;
         m_mpp    = m_mode;
         m_mode   = 3'b011;
         t_trap   = 1;
         n_flush  = 1;
      end else if (o.ret) begin
         exp_q.push_back(m_mepc);
         m_mie   = m_mpie;
         m_mpie  = 1;
         m_mode  = m_mpp;
         m_mpp   = 3'b000;
         t_ret   = 1;
         n_flush = 1;
      end

      if (o.wr) begin
         case (o.addr)
            12'h300: if (!t_trap && !t_ret) begin
               m_mie  = o.data[3];
               m_mpie = o.data[7];
               m_mpp  = 3'((o.data >> 11) % 4);
            end
            12'h305: m_mtvec = o.data & ~32'h2;
            12'h341: if (!t_trap) m_mepc = o.data & ~32'h1;
            12'h342: if (!t_trap) m_mcause = o.data;
            12'h343: if (!t_trap) m_mtval = o.data;
            12'h7b1: if (!t_dbg) m_dpc = o.data;
            default: ;
         endcase
      end

      @(posedge clk);
      #1;
      m_flush = n_flush;
      idle_inputs();
      check_outputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      model_reset();
      check_outputs();
      chk("reset_redirect_pc", trap_redirect__pc, 32'h0);
   endtask

   function automatic op_t mk_trap(input logic [3:0] cause, input logic [31:0] pc,
                                   input logic [31:0] value, input logic irq);
      op_t o;
      o = nop();
      o.valid = 1; o.cause = cause; o.pc = pc; o.value = value; o.irq = irq;
      return o;
   endfunction

   function automatic op_t mk_wr(input logic [11:0] addr, input logic [31:0] data);
      op_t o;
      o = nop();
      o.wr = 1; o.addr = addr; o.data = data;
      return o;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (trap_redirect__valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL redirect_unexpected: got pc 0x%08h expected no redirect at %0t",
                     trap_redirect__pc, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("redirect_pc", trap_redirect__pc, mon_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      op_t o;
      logic [11:0] addrs [0:6];
      addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;
      addrs[4] = 12'h343; addrs[5] = 12'h7b1; addrs[6] = 12'h344;

      idle_inputs();
      model_reset();
      reset = 1;
      repeat (3) @(posedge clk);
      do_reset();

      // synchronous exception to direct mtvec
      apply(mk_trap(4'd2, 32'h200, 32'h13, 1'b0));
      apply(nop());

      // vectored interrupt
      apply(mk_wr(12'h305, 32'h1001));
      apply(mk_wr(12'h300, 32'h0000_0008));
      apply(mk_trap(4'd7, 32'h400, 32'h0, 1'b1));
      apply(nop());

      // mret restores MIE from MPIE
      apply(mk_wr(12'h300, 32'h0000_0080));
      o = nop(); o.ret = 1;
      apply(o);
      apply(nop());

      // trap and mret together: trap wins
      o = mk_trap(4'd3, 32'h604, 32'h55, 1'b0); o.ret = 1;
      apply(o);
      apply(nop());

      // trap with colliding mepc write, non-colliding mtvec write
      o = mk_trap(4'd5, 32'h701, 32'h66, 1'b0); o.wr = 1; o.addr = 12'h341; o.data = 32'h500;
      apply(o);
      apply(mk_trap(4'd9, 32'h900, 32'h77, 1'b0));   // dropped while flushing
      o = mk_trap(4'd1, 32'h800, 32'h1, 1'b1); o.wr = 1; o.addr = 12'h305; o.data = 32'h2003;
      apply(o);
      apply(nop());

      // debug entry, ignored trap, dpc write, resume
      o = mk_trap(4'd3, 32'h300, 32'h0, 1'b0); o.dbg = 1;
      apply(o);
      apply(mk_trap(4'd2, 32'hA00, 32'h0, 1'b0));
      apply(mk_wr(12'h7b1, 32'h304));
      o = nop(); o.resume = 1;
      apply(o);
      apply(nop());

      // reset while halted
      o = mk_trap(4'd3, 32'h320, 32'h0, 1'b0); o.dbg = 1;
      apply(o);
      apply(mk_wr(12'h305, 32'h4000));
      do_reset();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         o = nop();
         o.valid  = ($urandom_range(0, 9) < 3);
         o.dbg    = ($urandom_range(0, 9) < 2);
         o.ret    = ($urandom_range(0, 9) < 3);
         o.irq    = 1'($urandom_range(0, 1));
         o.cause  = 4'($urandom_range(0, 15));
         o.pc     = $urandom;
         o.value  = $urandom;
         o.wr     = ($urandom_range(0, 9) < 4);
         o.addr   = addrs[$urandom_range(0, 6)];
         o.data   = $urandom;
         o.resume = 1'($urandom_range(0, 1));
         apply(o);
      end

      // drain: leave halted if needed, let the last redirect go by
      o = nop(); o.resume = 1;
      apply(o);
      repeat (3) apply(nop());
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/riscv_i32_trap_handler.md
# riscv_i32_trap_handler

Sequential consumer of the control-flow trap interface in the RV32I pipeline. It takes the per-cycle trap/return/interrupt indication, updates the machine trap CSRs (mstatus.MIE/MPIE/MPP, mepc, mcause, mtval, mtvec) and the debug PC. It issues a one-cycle registered fetch redirect to the trap vector, mepc or dpc, and holds the core in a debug-halted state on ebreak-to-debug until the debugger resumes it.

## Interface
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec (bit 1 forced 0)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous active-high reset
- control_flow__trap__valid  input  1  trap request this cycle
- control_flow__trap__to_mode  input  3  target mode (3'b011 machine only is honoured)
- control_flow__trap__cause  input  4  exception/interrupt number
- control_flow__trap__pc  input  32  PC of trapping instruction
- control_flow__trap__value  input  32  mtval value
- control_flow__trap__ret  input  1  mret executed
- control_flow__trap__vector  input  1  reserved; ignored
- control_flow__trap__ebreak_to_dbg  input  1  trap enters debug instead of machine trap
- control_flow__async_cancel  input  1  trap is an interrupt
- csr_write__valid  input  1  CSR write strobe
- csr_write__address  input  12  0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x7b1 dpc
- csr_write__data  input  32  write data
- dbg_resume  input  1  leave debug-halted state
- trap_redirect__valid  output  1  fetch redirect, one cycle
- trap_redirect__pc  output  32  redirect target
- csrs__mepc, csrs__mcause, csrs__mtval, csrs__mtvec  output  32 each  current CSR values
- csrs__mstatus_mie  output  1  global interrupt enable
- csrs__mode  output  3  current privilege mode
- dbg_halted  output  1  core halted in debug

## Operation
- States: IDLE, REDIRECT, HALTED. Reset -> IDLE.
- IDLE, trap__valid & !ebreak_to_dbg: mepc <= {pc[31:1],0}; mcause <= {async_cancel, 27'b0, cause}; mtval <= value; MPIE <= MIE; MIE <= 0; MPP <= mode; mode <= 3'b011. Target = interrupt & mtvec[0] ? {mtvec[31:2],2'b0} + 4*cause : {mtvec[31:2],2'b0}. Next REDIRECT.
- IDLE, trap__valid & ebreak_to_dbg: dpc <= pc; machine CSRs unchanged; next HALTED.
- IDLE, trap__ret & !trap__valid: MIE <= MPIE; MPIE <= 1; mode <= MPP; MPP <= 3'b000; target = mepc; next REDIRECT.
- trap__valid has priority over trap__ret in the same cycle.
- REDIRECT: trap_redirect__valid=1, pc=latched target, for exactly one cycle; trap inputs ignored (pipeline is flushing); next IDLE.
- HALTED: dbg_halted=1; trap inputs ignored; dbg_resume -> latch target = dpc, next REDIRECT. CSR writes accepted while halted.
- CSR writes: applied in any state. mstatus write updates MIE(bit3), MPIE(bit7), MPP(bits12:11 -> mode 3'b0xx); mtvec bit 1 forced 0; mepc bit 0 forced 0. A write colliding with a same-cycle trap/ret update of the same register loses; writes to non-colliding registers apply.
- Unlisted addresses ignored. csrs__mstatus_mie and csrs__mode reflect registered state.

## Timing
- Reset values: trap_redirect__valid 0, trap_redirect__pc 0, mepc/mcause/mtval 0, mtvec MTVEC_RESET, MIE 0, MPIE 0, mode 3'b011, dpc 0, dbg_halted 0.
- Trap/ret in cycle N: CSRs visible N+1; trap_redirect__valid high in N+1 only.
- dbg_resume in cycle N (HALTED): dbg_halted low N+1, redirect valid N+1.
- CSR write cycle N visible N+1.
- Reset in REDIRECT or HALTED: next cycle IDLE, no redirect.
- Outputs all registered; no combinational input->output path.

## Test plan
- Reset, then trap valid cause=2 pc=0x200 value=0x13 -> N+1 redirect pc=0x100, mepc=0x200, mcause=0x2, mtval=0x13, MIE=0; N+2 redirect low.
- mtvec written 0x1001, MIE=1; interrupt (async_cancel=1) cause=7 -> redirect 0x101C, mcause=0x80000007, MPIE=1, MIE=0.
- After trap, mret -> redirect=mepc, MIE=1 (restored from MPIE), MPIE=1, mode=MPP.
- Same-cycle trap_valid and ret -> trap taken, redirect to mtvec; same-cycle trap and mepc write 0x500 -> mepc = trap pc.
- ebreak_to_dbg pc=0x300 -> dbg_halted=1, no redirect, mepc unchanged; write dpc 0x304, dbg_resume -> redirect 0x304, dbg_halted 0.
- Reset asserted while HALTED -> dbg_halted 0, redirect 0, mtvec=MTVEC_RESET next cycle.
